prog_loader: RTL and testbench
==============================

# prog_loader

Byte-stream program loader for the 8-bit RISC CPU. It accepts a framed program image on a valid/ready byte interface and writes it into the CPU's 32x8 instruction/data memory starting at address 0. It holds the CPU in reset while loading, verifies a checksum, then releases the CPU and watches HALT. It replaces the bench-driven reset/boot sequence with a hardware boot path.

## Interface
- WIDTH_REG, 8: data/byte width, which is also the memory word width.
- ADDR_WIDTH, 5: memory address width, matching the CPU PC; capacity is 2^ADDR_WIDTH words.
- HEADER, 8'hA5: frame start byte.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- in_valid  in  1  byte-stream valid.
- in_data  in  WIDTH_REG  byte-stream data.
- in_ready  out  1  loader can accept a byte; a byte transfers when in_valid && in_ready at a rising edge.
- mem_we  out  1  memory write strobe, one cycle per word.
- mem_addr  out  ADDR_WIDTH  memory write address.
- mem_wdata  out  WIDTH_REG  memory write data.
- cpu_reset  out  1  active-high reset to the CPU core.
- cpu_halt  in  1  HALT from the CPU core.
- done  out  1  high while the CPU is running a verified image.
- error  out  1  sticky error flag; cleared only by a new header or by reset.

## Operation
- Frame format: HEADER, LEN, LEN data bytes, CHK. LEN must be 1..2^ADDR_WIDTH. CHK is chosen so that the 8-bit sum of all data bytes plus CHK equals 0 mod 256.
- States: IDLE, LEN, DATA, CHK, RUN, ERR.
- IDLE: in_ready=1. An accepted HEADER moves to LEN; any other byte is dropped.
- LEN: in_ready=1. An accepted byte with LEN==0 or LEN>2^ADDR_WIDTH moves to ERR. Otherwise latch the count, clear the address and sum to 0, and move to DATA.
- DATA: in_ready=1. Each accepted byte:
  - writes to mem_addr = current address;
  - adds to the sum, truncated to 8 bits;
  - increments the address.
  - After the LEN-th byte, move to CHK.
- CHK: in_ready=1. Accepted byte: if (sum+byte) mod 256 == 0, move to RUN, else to ERR.
- RUN: cpu_reset=0, done=1, in_ready=1.
  - An accepted HEADER restarts the load: go to LEN and reassert cpu_reset.
  - Other bytes are dropped.
  - cpu_halt=1 returns to IDLE, dropping done and reasserting cpu_reset.
- ERR: error=1, cpu_reset=1, in_ready=1. An accepted HEADER clears error and moves to LEN; other bytes are dropped.
- cpu_reset is 1 in every state except RUN.
- Memory contents written before a failed CHK are left in place; the CPU never runs them.
- The address counter is ADDR_WIDTH wide. LEN==2^ADDR_WIDTH writes every word and the counter wraps to 0 after the last word; the length check, not the counter, bounds the write.
- The LEN count register is ADDR_WIDTH+1 bits so that LEN==32 is representable.

## Timing
- Reset (reset==0 at an edge) puts all outputs in this state on the next edge:
  - state=IDLE, in_ready=1, cpu_reset=1;
  - mem_we=0, mem_addr=0, mem_wdata=0;
  - done=0, error=0.
- Reset mid-frame discards the frame; reset in RUN reasserts cpu_reset.
- Throughput: one byte per cycle, no bubbles. in_ready is never deasserted after reset.
- mem_we, mem_addr and mem_wdata are registered. They are valid in the cycle after the DATA byte is accepted, and mem_we is high for exactly one cycle per data byte.
- State transitions take effect the cycle after the accepting edge. cpu_reset falls and done rises one cycle after CHK is accepted.
- The last mem_we pulse coincides with the CHK-accept cycle or earlier, so memory is complete before cpu_reset falls.
- cpu_halt is sampled only in RUN; it is ignored in all other states.
- cpu_halt and an accepted HEADER in the same RUN cycle: HEADER wins and the loader goes to LEN.
- in_valid low stalls any state indefinitely; there is no timeout.

## Test plan
- Reset then frame A5,03,11,22,33,9A: exactly three mem_we pulses with (addr,data) = (0,11),(1,22),(2,33). cpu_reset falls one cycle after 9A is accepted, done=1, error=0.
- Same frame with CHK=9B: three writes occur, then error=1, cpu_reset stays 1, done=0. A following valid frame clears error and ends in RUN.
- LEN=00, and separately LEN=21 (33): ERR entered immediately, no mem_we pulses.
- LEN=20 with 32 bytes: writes to addresses 0..31 in order, then RUN.
- In RUN, cpu_halt=1 for one cycle: next cycle done=0 and cpu_reset=1, state IDLE. Junk bytes 00,FF are then dropped with no writes.
- Stalls and reset:
  - in_valid toggled randomly during a frame: same writes and result as back-to-back delivery.
  - reset=0 asserted after two data bytes: no further writes, outputs return to reset values, and the next full frame loads normally.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: boots the 8-bit RISC CPU from a framed byte stream.
// The frame is HEADER, LEN, LEN data bytes, CHK. Data bytes are written into
// the 32x8 instruction/data memory from address 0. The CPU is held in reset
// until the checksum verifies, and it runs until it raises HALT.

module prog_loader #(
    parameter int                   WIDTH_REG  = 8,
    parameter int                   ADDR_WIDTH = 5,
    parameter logic [WIDTH_REG-1:0] HEADER     = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [WIDTH_REG-1:0]  in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH_REG-1:0]  mem_wdata,
    output logic                  cpu_reset,
    input  logic                  cpu_halt,
    output logic                  done,
    output logic                  error
);

    // Largest legal LEN is the full memory depth, which still fits in a byte.
    localparam logic [WIDTH_REG-1:0]  MAX_LEN  = WIDTH_REG'(1 << ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0]   LAST_ONE = (ADDR_WIDTH+1)'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_CHK,
        ST_RUN,
        ST_ERR
    } state_t;

    state_t                  state_q,     state_d;
    logic [ADDR_WIDTH:0]     left_q,      left_d;
    logic [ADDR_WIDTH-1:0]   addr_q,      addr_d;
    logic [WIDTH_REG-1:0]    sum_q,       sum_d;
    logic                    mem_we_q,    mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q,  mem_addr_d;
    logic [WIDTH_REG-1:0]    mem_wdata_q, mem_wdata_d;

    logic                    ready;
    logic                    accept;
    logic                    isHeader;
    logic                    lenBad;
    logic [WIDTH_REG-1:0]    chkSum;

    // The loader always has room for a byte, so a transfer is just in_valid.
    assign ready    = 1'b1;
    assign accept   = in_valid && ready;
    assign isHeader = accept && (in_data == HEADER);
    assign lenBad   = (in_data == '0) || (in_data > MAX_LEN);
    assign chkSum   = sum_q + in_data;

    // Next-state and datapath decisions for every frame position.
    always_comb begin
        state_d     = state_q;
        left_d      = left_q;
        addr_d      = addr_q;
        sum_d       = sum_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (isHeader) begin
                    state_d = ST_LEN;
                end
            end

            ST_LEN: begin
                if (accept) begin
                    if (lenBad) begin
                        state_d = ST_ERR;
                    end else begin
                        left_d  = in_data[ADDR_WIDTH:0];
                        addr_d  = '0;
                        sum_d   = '0;
                        state_d = ST_DATA;
                    end
                end
            end

            ST_DATA: begin
                if (accept) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = in_data;
                    sum_d       = sum_q + in_data;
                    addr_d      = addr_q + 1'b1;
                    left_d      = left_q - 1'b1;
                    if (left_q == LAST_ONE) begin
                        state_d = ST_CHK;
                    end
                end
            end

            ST_CHK: begin
                if (accept) begin
                    if (chkSum == '0) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end

            ST_RUN: begin
                if (isHeader) begin
                    state_d = ST_LEN;
                end else if (cpu_halt) begin
                    state_d = ST_IDLE;
                end
            end

            ST_ERR: begin
                if (isHeader) begin
                    state_d = ST_LEN;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            left_q      <= '0;
            addr_q      <= '0;
            sum_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            left_q      <= left_d;
            addr_q      <= addr_d;
            sum_q       <= sum_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign in_ready  = ready;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_reset = (state_q != ST_RUN);
    assign done      = (state_q == ST_RUN);
    assign error     = (state_q == ST_ERR);

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed frames against a frame-level reference model of the
// loader, plus hand-computed expectations for each scenario.

module tb_prog_loader;

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = 8'h00;
    logic       cpu_halt = 1'b0;
    logic       in_ready;
    logic       mem_we;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_reset;
    logic       done;
    logic       error;

    int nAssert = 0;
    int nFail   = 0;
    bit checkEn = 1'b0;
    bit stallMode = 1'b0;

    logic [12:0] writeLog[$];
    logic [7:0]  frameQ[$];

    // Reference model: position within a frame, running sum, expected writes.
    localparam int P_IDLE = 0;
    localparam int P_LEN  = 1;
    localparam int P_DATA = 2;
    localparam int P_CHK  = 3;
    localparam int P_RUN  = 4;
    localparam int P_ERR  = 5;

    int         mPhase = P_IDLE;
    int         mLeft  = 0;
    int         mAddr  = 0;
    int         mSum   = 0;
    logic       expWe   = 1'b0;
    logic [4:0] expAddr = 5'd0;
    logic [7:0] expData = 8'd0;

    prog_loader dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_reset (cpu_reset),
        .cpu_halt  (cpu_halt),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nAssert++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model on each rising edge from the inputs the DUT sees.
    always @(posedge clk) begin
        if (!reset) begin
            mPhase  = P_IDLE;
            mLeft   = 0;
            mAddr   = 0;
            mSum    = 0;
            expWe   = 1'b0;
            expAddr = 5'd0;
            expData = 8'd0;
        end else begin
            expWe = 1'b0;
            case (mPhase)
                P_IDLE: if (in_valid && in_data == 8'hA5) mPhase = P_LEN;
                P_LEN: if (in_valid) begin
                    if (in_data == 0 || int'(in_data) > 32) begin
                        mPhase = P_ERR;
                    end else begin
                        mLeft  = int'(in_data);
                        mAddr  = 0;
                        mSum   = 0;
                        mPhase = P_DATA;
                    end
                end
                P_DATA: if (in_valid) begin
                    expWe   = 1'b1;
                    expAddr = 5'(mAddr);
                    expData = in_data;
                    mSum    = (mSum + int'(in_data)) % 256;
                    mAddr   = (mAddr + 1) % 32;
                    mLeft   = mLeft - 1;
                    if (mLeft == 0) mPhase = P_CHK;
                end
                P_CHK: if (in_valid) mPhase = ((mSum + int'(in_data)) % 256 == 0) ? P_RUN : P_ERR;
                P_RUN: begin
                    if (in_valid && in_data == 8'hA5) mPhase = P_LEN;
                    else if (cpu_halt) mPhase = P_IDLE;
                end
                P_ERR: if (in_valid && in_data == 8'hA5) mPhase = P_LEN;
                default: mPhase = P_IDLE;
            endcase
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("in_ready",  in_ready,  1);
            checkOutput("cpu_reset", cpu_reset, mPhase != P_RUN);
            checkOutput("done",      done,      mPhase == P_RUN);
            checkOutput("error",     error,     mPhase == P_ERR);
            checkOutput("mem_we",    mem_we,    expWe);
            checkOutput("mem_addr",  mem_addr,  expAddr);
            checkOutput("mem_wdata", mem_wdata, expData);
            if (mem_we) writeLog.push_back({mem_addr, mem_wdata});
        end
    end

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic h);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        cpu_halt = h;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 8'($urandom), 1'b0);
    endtask

    task automatic sendQueue();
        foreach (frameQ[i]) begin
            if (stallMode) idle($urandom_range(0, 2));
            applyStimulus(1'b1, frameQ[i], 1'b0);
        end
        frameQ.delete();
    endtask

    task automatic checkFrameA(input string tag);
        checkOutput({tag, "_count"}, writeLog.size(), 3);
        checkOutput({tag, "_w0"}, writeLog[0], {5'd0, 8'h11});
        checkOutput({tag, "_w1"}, writeLog[1], {5'd1, 8'h22});
        checkOutput({tag, "_w2"}, writeLog[2], {5'd2, 8'h33});
    endtask

    initial begin
        logic [7:0] sum;
        logic [7:0] b;

        // Reset state.
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checkEn = 1'b1;
        checkOutput("rst_in_ready",  in_ready,  1);
        checkOutput("rst_cpu_reset", cpu_reset, 1);
        checkOutput("rst_done",      done,      0);
        checkOutput("rst_error",     error,     0);
        checkOutput("rst_mem_we",    mem_we,    0);
        checkOutput("rst_mem_addr",  mem_addr,  0);
        reset = 1'b1;
        idle(2);

        // Good frame A.
        writeLog.delete();
        frameQ = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h9A};
        sendQueue();
        idle(1);
        checkOutput("A_done",      done,      1);
        checkOutput("A_cpu_reset", cpu_reset, 0);
        checkOutput("A_error",     error,     0);
        idle(2);
        checkFrameA("A");

        // HALT returns to IDLE; junk is then dropped.
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("halt_done",      done,      0);
        checkOutput("halt_cpu_reset", cpu_reset, 1);
        writeLog.delete();
        frameQ = '{8'h00, 8'hFF};
        sendQueue();
        idle(2);
        checkOutput("junk_writes", writeLog.size(), 0);
        checkOutput("junk_done",   done,  0);
        checkOutput("junk_error",  error, 0);

        // Bad checksum, then recovery with a good frame.
        frameQ = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h9B};
        sendQueue();
        idle(2);
        checkOutput("bad_error",     error,     1);
        checkOutput("bad_cpu_reset", cpu_reset, 1);
        checkOutput("bad_done",      done,      0);
        checkFrameA("bad");
        writeLog.delete();
        applyStimulus(1'b1, 8'hA5, 1'b0);
        idle(1);
        checkOutput("hdr_clears_error", error, 0);
        frameQ = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h9A};
        sendQueue();
        idle(2);
        checkOutput("recover_done", done, 1);
        checkFrameA("recover");

        // HEADER and HALT together in RUN: HEADER wins.
        applyStimulus(1'b1, 8'hA5, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("hdrhalt_cpu_reset", cpu_reset, 1);
        checkOutput("hdrhalt_done",      done,      0);
        writeLog.delete();
        frameQ = '{8'h01, 8'h55, 8'hAB};
        sendQueue();
        idle(2);
        checkOutput("hdrhalt_run",   done, 1);
        checkOutput("hdrhalt_write", writeLog[0], {5'd0, 8'h55});

        // Illegal lengths 0 and 33.
        writeLog.delete();
        frameQ = '{8'hA5, 8'h00};
        sendQueue();
        idle(1);
        checkOutput("len0_error", error, 1);
        applyStimulus(1'b1, 8'hA5, 1'b0);
        idle(1);
        checkOutput("len0_cleared", error, 0);
        applyStimulus(1'b1, 8'h21, 1'b0);
        idle(2);
        checkOutput("len33_error",  error, 1);
        checkOutput("len_bad_writes", writeLog.size(), 0);

        // Full 32-word image.
        writeLog.delete();
        sum = 8'h00;
        frameQ = '{8'hA5, 8'h20};
        for (int i = 0; i < 32; i++) begin
            b = 8'(i * 7 + 3);
            frameQ.push_back(b);
            sum = sum + b;
        end
        frameQ.push_back(8'h00 - sum);
        sendQueue();
        idle(2);
        checkOutput("full_done",  done, 1);
        checkOutput("full_count", writeLog.size(), 32);
        for (int i = 0; i < 32; i++) begin
            checkOutput("full_write", writeLog[i], {5'(i), 8'(i * 7 + 3)});
        end

        // Frame A with random stalls behaves like back-to-back delivery.
        writeLog.delete();
        stallMode = 1'b1;
        frameQ = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h9A};
        sendQueue();
        stallMode = 1'b0;
        idle(2);
        checkOutput("stall_done", done, 1);
        checkFrameA("stall");

        // Reset after two data bytes, then a normal reload.
        writeLog.delete();
        frameQ = '{8'hA5, 8'h03, 8'h11, 8'h22};
        sendQueue();
        applyStimulus(1'b0, 8'h00, 1'b0);
        reset = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("midrst_cpu_reset", cpu_reset, 1);
        checkOutput("midrst_mem_we",    mem_we,    0);
        checkOutput("midrst_mem_addr",  mem_addr,  0);
        checkOutput("midrst_mem_wdata", mem_wdata, 0);
        checkOutput("midrst_done",      done,      0);
        reset = 1'b1;
        idle(2);
        checkOutput("midrst_writes", writeLog.size(), 2);
        writeLog.delete();
        frameQ = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h9A};
        sendQueue();
        idle(2);
        checkOutput("reload_done", done, 1);
        checkFrameA("reload");

        idle(3);
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
